spi_ctrl: RTL

- Byte-oriented SPI master peripheral for tinyQV. Drives the display/SD-style SPI pins spi_cs (uo_out[0]), spi_sck (uo_out[1]), spi_mosi (uo_out[2]) and spi_dc (uo_out[3]), and samples spi_miso (ui_in[2]).
- Sits between the CPU peripheral bus decode, which writes data and config, and the top-level pin mux.
- Full-duplex, SPI mode 0, MSB first, with programmable SCK divider and MISO sample latency.

---
 rtl/tinyqv_periph_pkg.sv | 20 ++
 rtl/spi_ctrl_clk_div.sv | 33 +++
 rtl/spi_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tinyqv_periph_pkg.sv
// Shared definitions for tinyQV peripherals: SPI divider width, SPI FSM states
// and the bit layout of the SPI config register as seen by the bus decode.
package tinyqv_periph_pkg;

  localparam int SPI_DIV_WIDTH = 4;

  localparam int SPI_CFG_DIV_LSB = 0;
  localparam int SPI_CFG_DIV_MSB = 3;
  localparam int SPI_CFG_RL_BIT  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic logic [7:0] spi_shift_in(input logic [7:0] sh, input logic bit_in);
    return {sh[6:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_ctrl_clk_div.sv
// Loadable down-counter for the SPI master: strobes tick for one clk each
// time the count reaches zero, reloading with the current period.
module spi_clk_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_r;

  assign tick = enable & (cnt_r == {WIDTH{1'b0}});

  // Half-period counter: load on transfer start, reload on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= period;
    end else if (tick) begin
      cnt_r <= period;
    end else if (enable) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_ctrl.sv
// Byte-oriented SPI master (mode 0, MSB first, full duplex) for tinyQV with
// programmable SCK divider and selectable MISO sample edge.
module spi_ctrl
  import tinyqv_periph_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_config,
  input  logic [DIV_WIDTH-1:0] divider_in,
  input  logic                 read_latency_in,
  input  logic                 start,
  input  logic [7:0]           data_in,
  input  logic                 dc_in,
  input  logic                 end_txn,
  output logic                 busy,
  output logic [7:0]           data_out,
  input  logic                 spi_miso,
  output logic                 spi_select,
  output logic                 spi_clk_out,
  output logic                 spi_data_out,
  output logic                 spi_dc
);

  spi_state_e           state_r, state_s;
  logic                 busy_r, busy_s;
  logic                 cs_r, cs_s;
  logic                 sck_r, sck_s;
  logic                 mosi_r, mosi_s;
  logic                 dc_r, dc_s;
  logic [7:0]           sh_r, sh_s;
  logic [2:0]           bit_r, bit_s;
  logic                 end_r, end_s;
  logic [7:0]           dout_r, dout_s;
  logic [DIV_WIDTH-1:0] div_r, div_s;
  logic                 rl_r, rl_s;

  logic [7:0]           fall_sh_s;
  logic [DIV_WIDTH-1:0] div_eff_s;
  logic                 div_load_s;
  logic                 div_en_s;
  logic                 tick_s;

  // A config write coinciding with start must already govern that transfer.
  assign div_eff_s  = ((state_r == IDLE) && set_config) ? divider_in : div_r;
  assign div_load_s = (state_r == IDLE) && start;
  assign div_en_s   = (state_r == SHIFT);

  spi_clk_div #(
    .WIDTH (DIV_WIDTH)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (div_load_s),
    .enable (div_en_s),
    .period (div_eff_s),
    .tick   (tick_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      cs_r    <= 1'b1;
      sck_r   <= 1'b0;
      mosi_r  <= 1'b0;
      dc_r    <= 1'b0;
      sh_r    <= 8'h00;
      bit_r   <= 3'd0;
      end_r   <= 1'b0;
      dout_r  <= 8'h00;
      div_r   <= {DIV_WIDTH{1'b0}};
      rl_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      cs_r    <= cs_s;
      sck_r   <= sck_s;
      mosi_r  <= mosi_s;
      dc_r    <= dc_s;
      sh_r    <= sh_s;
      bit_r   <= bit_s;
      end_r   <= end_s;
      dout_r  <= dout_s;
      div_r   <= div_s;
      rl_r    <= rl_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s   = state_r;
    busy_s    = busy_r;
    cs_s      = cs_r;
    sck_s     = sck_r;
    mosi_s    = mosi_r;
    dc_s      = dc_r;
    sh_s      = sh_r;
    bit_s     = bit_r;
    end_s     = end_r;
    dout_s    = dout_r;
    div_s     = div_r;
    rl_s      = rl_r;
    fall_sh_s = sh_r;

    case (state_r)
      IDLE: begin
        if (set_config) begin
          div_s = divider_in;
          rl_s  = read_latency_in;
        end else begin
          div_s = div_r;
          rl_s  = rl_r;
        end
        if (start) begin
          state_s = SHIFT;
          busy_s  = 1'b1;
          cs_s    = 1'b0;
          dc_s    = dc_in;
          mosi_s  = data_in[7];
          sh_s    = data_in;
          end_s   = end_txn;
          bit_s   = 3'd0;
          sck_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (tick_s) begin
          sck_s = ~sck_r;
          if (sck_r == 1'b0) begin
            // Rising edge: sample here only in zero-latency mode.
            if (rl_r == 1'b0) begin
              sh_s = spi_shift_in(sh_r, spi_miso);
            end else begin
              sh_s = sh_r;
            end
          end else begin
            if (rl_r == 1'b1) begin
              fall_sh_s = spi_shift_in(sh_r, spi_miso);
            end else begin
              fall_sh_s = sh_r;
            end
            sh_s  = fall_sh_s;
            bit_s = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_s = IDLE;
              busy_s  = 1'b0;
              dout_s  = fall_sh_s;
              cs_s    = end_r;
            end else begin
              mosi_s = fall_sh_s[7];
            end
          end
        end else begin
          sck_s = sck_r;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign busy         = busy_r;
  assign data_out     = dout_r;
  assign spi_select   = cs_r;
  assign spi_clk_out  = sck_r;
  assign spi_data_out = mosi_r;
  assign spi_dc       = dc_r;

endmodule
